dcache_2way: RTL
================

# dcache_2way

Two-way set-associative, write-back, write-allocate data cache. It is the parametrised successor of the single-way data cache, sitting between the processor data port and the 128-bit block memory. Set count and address width are configurable, and it replaces one-way direct mapping with true LRU replacement. It adds saturating hit, miss and write-back counters for performance measurement.

## Interface

Parameters:
- `ADDR_W`, default 30: processor word-address width.
- `SETS`, default 4: number of sets; must be a power of two, at least 2.
- `CNT_W`, default 16: width of the performance counters.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `proc_reset`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `proc_read`, in, 1: read request; held until `proc_stall` is low.
- `proc_write`, in, 1: write request; wins if asserted together with `proc_read`.
- `proc_addr`, in, `ADDR_W`: word address.
- `proc_wdata`, in, 32: write data.
- `proc_rdata`, out, 32: read data; valid when a read is not stalled.
- `proc_stall`, out, 1: request not complete this cycle.
- `mem_read`, out, 1: block read request.
- `mem_write`, out, 1: block write request.
- `mem_addr`, out, `ADDR_W-2`: block address.
- `mem_wdata`, out, 128: victim block data.
- `mem_rdata`, in, 128: fill data.
- `mem_ready`, in, 1: memory done; one-cycle pulse.
- `hit_count`, out, `CNT_W`: saturating count of first-try hits.
- `miss_count`, out, `CNT_W`: saturating count of misses.
- `wb_count`, out, `CNT_W`: saturating count of dirty evictions.

## Operation

Address fields:
- `word = proc_addr[1:0]`.
- `set = proc_addr[S+1:2]`, where S = log2(SETS).
- `tag = proc_addr[ADDR_W-1:S+2]`.

Line state: valid, dirty, tag and 128-bit data per line; one LRU bit per set, naming the way to evict.

Input registering: `mem_ready` and `mem_rdata` are registered as `ready_r` and `rdata_r` before use.

FSM states:
- COMP:
  - On a request with a hit in way w:
    - a read returns the selected word combinationally;
    - a write merges `proc_wdata` into that word and sets dirty;
    - LRU for the set becomes !w.
  - On a miss, the victim is chosen and latched into `victim_r`:
    - first invalid way, with way 0 preferred;
    - otherwise the LRU way.
  - Next state is WB if the victim is valid and dirty, else ALLC.
- WB:
  - `mem_write = !ready_r`.
  - `mem_addr = {victim tag, set}`.
  - `mem_wdata` = victim data.
  - When `ready_r` is 1, go to ALLC.
- ALLC:
  - `mem_read = !ready_r`.
  - `mem_addr = proc_addr[ADDR_W-1:2]`.
  - When `ready_r` is 1:
    - the victim line takes valid=1, dirty=0, the new tag and `rdata_r`;
    - go to COMP.

Stall and access completion:
- `proc_stall = (state != COMP) | ((proc_read | proc_write) & !hit)`.
- The access completes as a hit in COMP on the cycle after the fill.
- A write miss therefore completes through the normal write-hit path.

Counters:
- `miss_count` increments on each COMP→WB or COMP→ALLC transition.
- `wb_count` increments on each WB→ALLC transition.
- `hit_count` increments on a hit in COMP only if the previous cycle was not ALLC, so a refilled access is not counted twice.
- All counters saturate at all-ones.

Idle cycles: no request means no LRU or counter update.

## Timing

Reset values (asynchronous assertion):
- state = COMP.
- All valid, dirty and LRU bits = 0.
- `victim_r` = 0; counters = 0.
- `ready_r` = 0; `rdata_r` = 0.
- `mem_read` = `mem_write` = 0 immediately.
- `proc_stall` = 0 with no request. Tag and data arrays are not reset.

Reset taking effect mid-operation:
- A reset asserted in WB or ALLC drops the memory request in the same cycle.
- A partially filled line is never marked valid.

Latency:
- Hit: 0 cycles of stall.
- Clean miss: memory latency L cycles (from `mem_read` rising to the `mem_ready` pulse) + 2 cycles of stall.
- Dirty miss: L_wb + L_rd + 3 cycles of stall.

Handshake:
- `mem_read` and `mem_write` are never both high.
- Each deasserts the cycle after `mem_ready` is sampled.
- `mem_addr` and `mem_wdata` are stable while a request is high.

## Structure

- Package `dcache_pkg`:
  - state enum {COMP, ALLC, WB};
  - localparams BLOCK_W=128, WORD_W=32, WORDS=4;
  - function `word_sel(block, idx)`.
- Sub-module `dcache_way` (two instances) contains:
  - the valid, dirty, tag and data arrays;
  - the hit compare;
  - word-merge write port and block fill port.
- The top level holds the FSM, LRU bits, victim select, memory input registers and counters.

## Test plan

SETS=4, so tag = addr[29:4] and `mem_addr` = addr[29:2].

- **Cold read miss.** Reset, then read 0x10.
  - `mem_read` high with `mem_addr` 0x4; ready with data {D3,D2,D1,D0}.
  - Stall ends; `proc_rdata` = D0; `miss_count` = 1, `hit_count` = 0.
- **Read hit.** Then read 0x12.
  - No stall, no memory request; `proc_rdata` = D2; `hit_count` = 1.
- **LRU eviction.** Fill set 0 with tags 1 (0x10) and 2 (0x20), re-read 0x10, then read 0x30.
  - Tag 2's way is replaced; a later read of 0x10 hits.
- **Dirty write-back.** Write 0xDEADBEEF to 0x20, touch 0x10, then read 0x30.
  - `mem_write` with `mem_addr` 0x8 and `mem_wdata[31:0]` = 0xDEADBEEF.
  - Then `mem_read` with `mem_addr` 0xC; `wb_count` = 1.
- **Reset mid-fill.** Assert `proc_reset` between clock edges during ALLC.
  - `mem_read` drops to 0 at once; all counters 0; the next read of the same address misses.
- **Counter saturation.** With CNT_W=4, perform 20 repeated hits.
  - `hit_count` = 15 and holds.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, block geometry and word select/merge helpers for the two-way data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        COMP = 2'd0,
        ALLC = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int WORDS      = 4;
    localparam int WORD_IDX_W = $clog2(WORDS);

    function automatic logic [WORD_W-1:0] word_sel(
        input logic [BLOCK_W-1:0]    block,
        input logic [WORD_IDX_W-1:0] idx
    );
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = block[31:0];
            2'd1:    w = block[63:32];
            2'd2:    w = block[95:64];
            2'd3:    w = block[127:96];
            default: w = block[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [BLOCK_W-1:0] word_merge(
        input logic [BLOCK_W-1:0]    block,
        input logic [WORD_IDX_W-1:0] idx,
        input logic [WORD_W-1:0]     word
    );
        logic [BLOCK_W-1:0] m;
        m = block;
        case (idx)
            2'd0:    m[31:0]   = word;
            2'd1:    m[63:32]  = word;
            2'd2:    m[95:64]  = word;
            2'd3:    m[127:96] = word;
            default: m         = block;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Processor-side and block-memory-side signals of the data cache.
interface dcache_if #(
    parameter int ADDR_W = 30
) ();
    import dcache_pkg::*;

    logic                proc_read;
    logic                proc_write;
    logic [ADDR_W-1:0]   proc_addr;
    logic [WORD_W-1:0]   proc_wdata;
    logic [WORD_W-1:0]   proc_rdata;
    logic                proc_stall;
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-3:0]   mem_addr;
    logic [BLOCK_W-1:0]  mem_wdata;
    logic [BLOCK_W-1:0]  mem_rdata;
    logic                mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

endinterface

// File: rtl/dcache_way.sv
// One way of the cache: valid/dirty/tag/data arrays, hit compare, word-merge write and block fill.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int SETS  = 4,
    parameter int SET_W = 2,
    parameter int TAG_W = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_W-1:0]      set_idx,
    input  logic [TAG_W-1:0]      tag,
    input  logic [WORD_IDX_W-1:0] word_idx,
    input  logic                  wr_en,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic                  fill_en,
    input  logic [BLOCK_W-1:0]    fill_data,
    output logic                  hit,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      line_tag,
    output logic [BLOCK_W-1:0]    line_data,
    output logic [WORD_W-1:0]     rd_word
);

    logic [SETS-1:0]    valid_r;
    logic [SETS-1:0]    dirty_r;
    logic [TAG_W-1:0]   tag_r  [SETS];
    logic [BLOCK_W-1:0] data_r [SETS];

    // Line state: a fill installs a clean valid line, a word write marks it dirty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (fill_en) begin
            valid_r[set_idx] <= 1'b1;
            dirty_r[set_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_r[set_idx] <= 1'b1;
        end
    end

    // Tag and data storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[set_idx]  <= tag;
            data_r[set_idx] <= fill_data;
        end else if (wr_en) begin
            data_r[set_idx] <= word_merge(data_r[set_idx], word_idx, wr_data);
        end
    end

    assign valid     = valid_r[set_idx];
    assign dirty     = dirty_r[set_idx];
    assign line_tag  = tag_r[set_idx];
    assign line_data = data_r[set_idx];
    assign hit       = valid_r[set_idx] && (tag_r[set_idx] == tag);
    assign rd_word   = word_sel(data_r[set_idx], word_idx);

endmodule

// File: rtl/dcache_2way.sv
// Two-way set-associative write-back, write-allocate data cache with true LRU and saturating perf counters.
module dcache_2way
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int SETS   = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    dcache_if.slave          bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - SET_W - 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_e               state_r, next_s;
    logic [SETS-1:0]      lru_r;
    logic                 victim_r;
    logic                 ready_r;
    logic [BLOCK_W-1:0]   rdata_r;
    logic                 prev_allc_r;

    logic [WORD_IDX_W-1:0] word_s;
    logic [SET_W-1:0]      set_s;
    logic [TAG_W-1:0]      tag_s;
    logic                  req_s, hit_s, hit_way_s, victim_sel_s;
    logic [1:0]            wr_en_s, fill_en_s;
    logic                  lru_upd_s, miss_evt_s, wb_evt_s, hit_evt_s;

    logic [1:0]            hit_w, valid_w, dirty_w;
    logic [TAG_W-1:0]      tag_w  [2];
    logic [BLOCK_W-1:0]    data_w [2];
    logic [WORD_W-1:0]     word_w [2];

    assign word_s = bus.proc_addr[1:0];
    assign set_s  = bus.proc_addr[SET_W+1:2];
    assign tag_s  = bus.proc_addr[ADDR_W-1:SET_W+2];

    for (genvar g = 0; g < 2; g++) begin : g_way
        dcache_way #(
            .SETS  (SETS),
            .SET_W (SET_W),
            .TAG_W (TAG_W)
        ) u_way (
            .clk       (clk),
            .rst       (proc_reset),
            .set_idx   (set_s),
            .tag       (tag_s),
            .word_idx  (word_s),
            .wr_en     (wr_en_s[g]),
            .wr_data   (bus.proc_wdata),
            .fill_en   (fill_en_s[g]),
            .fill_data (rdata_r),
            .hit       (hit_w[g]),
            .valid     (valid_w[g]),
            .dirty     (dirty_w[g]),
            .line_tag  (tag_w[g]),
            .line_data (data_w[g]),
            .rd_word   (word_w[g])
        );
    end

    assign req_s     = bus.proc_read | bus.proc_write;
    assign hit_s     = hit_w[0] | hit_w[1];
    assign hit_way_s = hit_w[1];
    // An empty way is always filled before anything is evicted, way 0 first
    assign victim_sel_s = !valid_w[0] ? 1'b0 :
                          !valid_w[1] ? 1'b1 : lru_r[set_s];

    assign bus.proc_stall = (state_r != COMP) | (req_s & ~hit_s);
    assign bus.proc_rdata = word_w[hit_way_s];
    assign bus.mem_wdata  = data_w[victim_r];

    // Next state, memory request and per-cycle update strobes
    always_comb begin
        next_s        = state_r;
        wr_en_s       = 2'b00;
        fill_en_s     = 2'b00;
        lru_upd_s     = 1'b0;
        miss_evt_s    = 1'b0;
        wb_evt_s      = 1'b0;
        hit_evt_s     = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = bus.proc_addr[ADDR_W-1:2];
        case (state_r)
            COMP: begin
                if (req_s && hit_s) begin
                    lru_upd_s = 1'b1;
                    hit_evt_s = ~prev_allc_r;
                    if (bus.proc_write) begin
                        wr_en_s[hit_way_s] = 1'b1;
                    end else begin
                        wr_en_s = 2'b00;
                    end
                end else if (req_s) begin
                    miss_evt_s = 1'b1;
                    if (valid_w[victim_sel_s] && dirty_w[victim_sel_s]) begin
                        next_s = WB;
                    end else begin
                        next_s = ALLC;
                    end
                end else begin
                    next_s = COMP;
                end
            end
            WB: begin
                bus.mem_write = ~ready_r;
                bus.mem_addr  = {tag_w[victim_r], set_s};
                if (ready_r) begin
                    wb_evt_s = 1'b1;
                    next_s   = ALLC;
                end else begin
                    next_s   = WB;
                end
            end
            ALLC: begin
                bus.mem_read = ~ready_r;
                if (ready_r) begin
                    fill_en_s[victim_r] = 1'b1;
                    next_s              = COMP;
                end else begin
                    next_s              = ALLC;
                end
            end
            default: begin
                next_s = COMP;
            end
        endcase
    end

    // State register, victim latch, LRU bits and registered memory inputs
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_r     <= COMP;
            lru_r       <= '0;
            victim_r    <= 1'b0;
            ready_r     <= 1'b0;
            rdata_r     <= '0;
            prev_allc_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            ready_r     <= bus.mem_ready;
            rdata_r     <= bus.mem_rdata;
            prev_allc_r <= (state_r == ALLC);
            if (miss_evt_s) begin
                victim_r <= victim_sel_s;
            end
            if (lru_upd_s) begin
                lru_r[set_s] <= ~hit_way_s;
            end
        end
    end

    // Saturating performance counters; a refilled access is counted only as a miss
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_evt_s) begin
                hit_count <= sat_inc(hit_count);
            end
            if (miss_evt_s) begin
                miss_count <= sat_inc(miss_count);
            end
            if (wb_evt_s) begin
                wb_count <= sat_inc(wb_count);
            end
        end
    end

endmodule
